// File: rtl/pio_flag_bank_pkg.sv
// pio_flag_bank_pkg: register map, pulse FSM encoding and bit indices
// shared by the flag bank top and its pulse timer.
package pio_flag_bank_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLR    = 3'd2;
   localparam logic [2:0] ADDR_TGL    = 3'd3;
   localparam logic [2:0] ADDR_PMASK  = 3'd4;
   localparam logic [2:0] ADDR_PLEN   = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;
   localparam logic [2:0] ADDR_IRQ    = 3'd7;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int IRQ_PEND_BIT    = 0;
   localparam int IRQ_ENA_BIT     = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// pio_pulse_timer: shared down-counter behind the auto-clearing pulse bits.
// A trigger (re)loads the counter with len from any state; expire fires for
// one cycle when the count runs out with no trigger in the same cycle.
module pio_pulse_timer
   import pio_flag_bank_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trigger,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             expire
);

   pulse_state_t     state;
   pulse_state_t     state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // State and counter registers; reset abandons any count without expiring.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Retrigger restarts the full length; otherwise count down and expire at 1.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      expire     = 1'b0;
      if (trigger) begin
         cnt_next   = len;
         state_next = ST_COUNT;
      end else if (state == ST_COUNT) begin
         if (cnt <= CNT_W'(1)) begin
            expire     = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
         end else begin
            cnt_next = cnt - CNT_W'(1);
         end
      end
   end

   assign busy = (state == ST_COUNT);

endmodule

// File: rtl/pio_flag_bank.sv
// pio_flag_bank: Avalon-MM output-flag PIO with atomic SET/CLR/TOGGLE and
// auto-clearing pulse bits. Optional interrupt on pulse expiry is built
// when the macro PIO_IRQ_EN is defined; otherwise address 7 reads zero.
module pio_flag_bank
   import pio_flag_bank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
`ifdef PIO_IRQ_EN
   ,
   output logic             irq
`endif
);

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_wr;
   logic [WIDTH-1:0] data_d;
   logic             wr_data;
   logic [WIDTH-1:0] pmask_reg;
   logic [CNT_W-1:0] plen_reg;
   logic             trigger;
   logic             busy;
   logic             expire;
   logic             unused_ok;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_ok = &{1'b0, writedata};

   // Value DATA would take from the bus write alone, before any expiry clear.
   always_comb begin
      data_wr = data_reg;
      wr_data = 1'b0;
      if (wr) begin
         case (address)
            ADDR_DATA: begin data_wr = wd;             wr_data = 1'b1; end
            ADDR_SET:  begin data_wr = data_reg | wd;  wr_data = 1'b1; end
            ADDR_CLR:  begin data_wr = data_reg & ~wd; wr_data = 1'b1; end
            ADDR_TGL:  begin data_wr = data_reg ^ wd;  wr_data = 1'b1; end
            default:   begin data_wr = data_reg;       wr_data = 1'b0; end
         endcase
      end
   end

   assign trigger = wr_data && (|(data_wr & pmask_reg)) && (|plen_reg);

   // The timer only expires when nothing retriggered, so the write always wins.
   assign data_d = expire ? (data_wr & ~pmask_reg) : data_wr;

   // Register file: DATA, pulse mask and pulse length.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg  <= RESET_VAL;
         pmask_reg <= '0;
         plen_reg  <= '0;
      end else begin
         data_reg <= data_d;
         if (wr && address == ADDR_PMASK) pmask_reg <= wd;
         if (wr && address == ADDR_PLEN)  plen_reg  <= writedata[CNT_W-1:0];
      end
   end

   assign out_port = data_reg;

   pio_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger),
      .len     (plen_reg),
      .busy    (busy),
      .expire  (expire)
   );

`ifdef PIO_IRQ_EN
   logic irq_pend;
   logic irq_ena;

   // Sticky pending flag; a new expiry beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_pend <= 1'b0;
         irq_ena  <= 1'b0;
      end else begin
         if (expire)
            irq_pend <= 1'b1;
         else if (wr && address == ADDR_IRQ && writedata[IRQ_PEND_BIT])
            irq_pend <= 1'b0;
         if (wr && address == ADDR_IRQ)
            irq_ena <= writedata[IRQ_ENA_BIT];
      end
   end

   assign irq = irq_pend & irq_ena;
`endif

   // Zero-latency read mux; write-only registers read as zero.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata[WIDTH-1:0] = data_reg;
         ADDR_PMASK:  readdata[WIDTH-1:0] = pmask_reg;
         ADDR_PLEN:   readdata[CNT_W-1:0] = plen_reg;
         ADDR_STATUS: readdata[STATUS_BUSY_BIT] = busy;
`ifdef PIO_IRQ_EN
         ADDR_IRQ: begin
            readdata[IRQ_PEND_BIT] = irq_pend;
            readdata[IRQ_ENA_BIT]  = irq_ena;
         end
`endif
         default:     readdata = '0;
      endcase
   end

endmodule
